lbus_responder: RTL

//  Crypto-FPGA end of the SAKURA-G local bus: responder to the control FPGA's lbus initiator.

---
 rtl/lbus_pkg.sv | 31 +++
 rtl/lbus_rd_mux.sv | 45 ++++
 rtl/lbus_responder.sv | 150 +++++++++++++++
 3 files changed

// File: rtl/lbus_pkg.sv
// Address map, CTRL/status bit positions and FSM encoding shared by the lbus responder files.
package lbus_pkg;

    localparam logic [15:0] ADDR_CTRL = 16'h0002;
    localparam logic [15:0] ADDR_KEY  = 16'h0100;
    localparam logic [15:0] ADDR_DIN  = 16'h0140;
    localparam logic [15:0] ADDR_DOUT = 16'h0180;
    localparam logic [15:0] ADDR_VER  = 16'hFFFC;

    // CTRL write bits and CTRL read (status) bits
    localparam int unsigned CTRL_START = 0;
    localparam int unsigned CTRL_KRDY  = 1;
    localparam int unsigned STAT_BUSY  = 1;
    localparam int unsigned STAT_TRIG  = 2;

    typedef logic [1:0] lbus_state_t;
    localparam lbus_state_t S_ADDR = 2'd0;
    localparam lbus_state_t S_CMD  = 2'd1;
    localparam lbus_state_t S_RD   = 2'd2;

    // True when addr selects one of nw consecutive even word addresses starting at base.
    function automatic logic word_hit(input logic [15:0] addr, input logic [15:0] base,
                                      input int unsigned nw);
        return !addr[0] && (addr >= base) && (32'(addr - base) < 2 * nw);
    endfunction

    function automatic logic [15:0] word_idx(input logic [15:0] addr, input logic [15:0] base);
        return (addr - base) >> 1;
    endfunction

endpackage

// File: rtl/lbus_rd_mux.sv
// Combinational read-data select: maps the latched lbus word address to a 16-bit register word.
module lbus_rd_mux
    import lbus_pkg::*;
#(
    parameter int unsigned BLK_W   = 128,
    parameter logic [15:0] VERSION = 16'h0001
) (
    input  logic [15:0]      addr_i,
    input  logic [BLK_W-1:0] key_i,
    input  logic [BLK_W-1:0] din_i,
    input  logic [BLK_W-1:0] dout_i,
    input  logic [15:0]      status_i,
    output logic [15:0]      data_o
);

    localparam int unsigned NW = BLK_W / 16;
    localparam int unsigned IW = (NW > 1) ? $clog2(NW) : 1;

    // Ascending word index puts the most significant word at index 0.
    logic [0:NW-1][15:0] key_w, din_w, dout_w;
    logic [IW-1:0]       key_idx, din_idx, dout_idx;

    assign key_w    = key_i;
    assign din_w    = din_i;
    assign dout_w   = dout_i;
    assign key_idx  = IW'(word_idx(addr_i, ADDR_KEY));
    assign din_idx  = IW'(word_idx(addr_i, ADDR_DIN));
    assign dout_idx = IW'(word_idx(addr_i, ADDR_DOUT));

    always_comb begin
        data_o = '0;
        if (addr_i == ADDR_CTRL) begin
            data_o = status_i;
        end else if (addr_i == ADDR_VER) begin
            data_o = VERSION;
        end else if (word_hit(addr_i, ADDR_KEY, NW)) begin
            data_o = key_w[key_idx];
        end else if (word_hit(addr_i, ADDR_DIN, NW)) begin
            data_o = din_w[din_idx];
        end else if (word_hit(addr_i, ADDR_DOUT, NW)) begin
            data_o = dout_w[dout_idx];
        end
    end

endmodule

// File: rtl/lbus_responder.sv
// SAKURA-G crypto-FPGA lbus responder: register file, bus FSM and cipher-core handshake.
// Optional capture trigger output enabled by defining LBUS_TRIG_OUT_EN.
module lbus_responder
    import lbus_pkg::*;
#(
    parameter int unsigned BLK_W   = 128,
    parameter logic [15:0] VERSION = 16'h0001
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic [15:0]      lbus_di_a,
    input  logic             lbus_wrn,
    input  logic             lbus_rdn,
    output logic [15:0]      lbus_do,
    output logic [BLK_W-1:0] key_o,
    output logic [BLK_W-1:0] din_o,
    output logic             krdy_o,
    output logic             start_o,
    input  logic [BLK_W-1:0] dout_i,
    input  logic             done_i,
    output logic             trig_o
);

    localparam int unsigned NW = BLK_W / 16;
    localparam int unsigned IW = (NW > 1) ? $clog2(NW) : 1;

    lbus_state_t         state_q, state_d;
    logic [15:0]         addr_q, addr_d;
    logic [15:0]         lbus_do_q, lbus_do_d;
    logic [0:NW-1][15:0] key_q, key_d, din_q, din_d;
    logic [BLK_W-1:0]    dout_q;
    logic                krdy_q, krdy_d, start_q, start_d, busy_q, busy_d;
    logic [15:0]         status, rd_data;
    logic [IW-1:0]       key_idx, din_idx;

    assign key_idx = IW'(word_idx(addr_q, ADDR_KEY));
    assign din_idx = IW'(word_idx(addr_q, ADDR_DIN));

    always_comb begin
        status            = '0;
        status[STAT_BUSY] = busy_q;
        status[STAT_TRIG] = trig_o;
    end

    lbus_rd_mux #(
        .BLK_W  (BLK_W),
        .VERSION(VERSION)
    ) u_rd_mux (
        .addr_i  (addr_q),
        .key_i   (key_q),
        .din_i   (din_q),
        .dout_i  (dout_q),
        .status_i(status),
        .data_o  (rd_data)
    );

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        lbus_do_d = lbus_do_q;
        key_d     = key_q;
        din_d     = din_q;
        krdy_d    = 1'b0;
        start_d   = 1'b0;
        busy_d    = busy_q;

        case (state_q)
            S_ADDR: begin
                if (!lbus_wrn) begin
                    addr_d  = lbus_di_a;
                    state_d = S_CMD;
                end
            end
            S_CMD: begin
                if (!lbus_wrn) begin
                    state_d = S_ADDR;
                end else if (!lbus_rdn) begin
                    lbus_do_d = rd_data;
                    state_d   = S_RD;
                end
            end
            S_RD: begin
                if (lbus_rdn) state_d = S_ADDR;
            end
            default: state_d = S_ADDR;
        endcase

        // Data beat: the write wins over a simultaneous read; all writes drop while busy.
        if (state_q == S_CMD && !lbus_wrn && !busy_q) begin
            if (addr_q == ADDR_CTRL) begin
                start_d = lbus_di_a[CTRL_START];
                krdy_d  = lbus_di_a[CTRL_KRDY];
            end
            if (word_hit(addr_q, ADDR_KEY, NW)) key_d[key_idx] = lbus_di_a;
            if (word_hit(addr_q, ADDR_DIN, NW)) din_d[din_idx] = lbus_di_a;
        end

        if (done_i)  busy_d = 1'b0;
        if (start_d) busy_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q   <= S_ADDR;
            addr_q    <= '0;
            lbus_do_q <= '0;
            key_q     <= '0;
            din_q     <= '0;
            dout_q    <= '0;
            krdy_q    <= 1'b0;
            start_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            lbus_do_q <= lbus_do_d;
            key_q     <= key_d;
            din_q     <= din_d;
            krdy_q    <= krdy_d;
            start_q   <= start_d;
            busy_q    <= busy_d;
            if (done_i) dout_q <= dout_i;
        end
    end

`ifdef LBUS_TRIG_OUT_EN
    logic trig_q;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            trig_q <= 1'b0;
        end else if (start_d) begin
            trig_q <= 1'b1;
        end else if (done_i) begin
            trig_q <= 1'b0;
        end
    end

    assign trig_o = trig_q;
`else
    assign trig_o = 1'b0;
`endif

    assign lbus_do = lbus_do_q;
    assign key_o   = key_q;
    assign din_o   = din_q;
    assign krdy_o  = krdy_q;
    assign start_o = start_q;

endmodule
